// File: rtl/vec_pkg.sv
// Shared types for the vector command front-end: opcode names, the queued command
// layout and the legal-opcode check.
package vec_pkg;

  localparam int unsigned vec_els_lp    = 12;
  localparam int unsigned vec_vlen_lp   = 4;
  localparam int unsigned vec_vdw_lp    = 6;
  localparam int unsigned vec_addr_w_lp = $clog2(vec_els_lp);
  localparam int unsigned vec_data_w_lp = vec_vlen_lp * vec_vdw_lp;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_MUL   = 4'b0010,
    OP_ADDS  = 4'b0100,
    OP_SUBS  = 4'b0101,
    OP_MULS  = 4'b0110,
    OP_READ  = 4'b1000,
    OP_WRITE = 4'b1001,
    OP_NOP   = 4'b1111
  } vec_op_e;

  typedef struct packed {
    vec_op_e                    op;
    logic [vec_addr_w_lp-1:0]   addr_a;
    logic [vec_addr_w_lp-1:0]   addr_b;
    logic [vec_addr_w_lp-1:0]   addr_d;
    logic [vec_vdw_lp-1:0]      scalar;
    logic [vec_data_w_lp-1:0]   w_data;
  } vec_cmd_s;

  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_ADDS, OP_SUBS, OP_MULS,
      OP_READ, OP_WRITE, OP_NOP: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/vec_cmd_fifo.sv
// Power-of-two command FIFO with wrap-bit pointers; head entry is visible
// combinationally and only leaves when the consumer pops it.
module vec_cmd_fifo #(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               empty_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int unsigned ptr_w_lp = $clog2(els_p) + 1;

  logic [ptr_w_lp-1:0] wr_ptr;
  logic [ptr_w_lp-1:0] rd_ptr;
  logic [width_p-1:0]  mem [els_p];
  logic                full;
  logic                enq;
  logic                deq;

  // Full when the wrap bits differ but the index bits coincide.
  assign full    = (wr_ptr[ptr_w_lp-1] != rd_ptr[ptr_w_lp-1]) &&
                   (wr_ptr[ptr_w_lp-2:0] == rd_ptr[ptr_w_lp-2:0]);
  assign empty_o = (wr_ptr == rd_ptr);
  assign ready_o = !full;
  assign enq     = v_i && !full;
  assign deq     = yumi_i && !empty_o;
  assign data_o  = mem[rd_ptr[ptr_w_lp-2:0]];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr[ptr_w_lp-2:0]] <= data_i;
  end

endmodule

// File: rtl/vec_cmd_dispatch.sv
// Host-side command front-end for the vector core: queues commands, issues them one at a
// time holding operands until completion, and buffers one read response.
module vec_cmd_dispatch
  import vec_pkg::*;
#(
  parameter int unsigned cmd_els_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic [3:0]               op_i,
  input  logic [vec_addr_w_lp-1:0] addrA_i,
  input  logic [vec_addr_w_lp-1:0] addrB_i,
  input  logic [vec_addr_w_lp-1:0] addrD_i,
  input  logic [vec_vdw_lp-1:0]    scalar_i,
  input  logic [vec_data_w_lp-1:0] w_data_i,
  output logic                     v_o,
  output logic [vec_data_w_lp-1:0] r_data_o,
  input  logic                     yumi_i,
  output logic                     err_o,
  output logic                     busy_o,
  output logic                     core_v_o,
  input  logic                     core_ready_i,
  output logic [3:0]               core_op_o,
  output logic [vec_addr_w_lp-1:0] core_addrA_o,
  output logic [vec_addr_w_lp-1:0] core_addrB_o,
  output logic [vec_addr_w_lp-1:0] core_addrD_o,
  output logic [vec_vdw_lp-1:0]    core_scalar_o,
  output logic [vec_data_w_lp-1:0] core_w_data_o,
  input  logic                     core_done_i,
  input  logic                     core_v_i,
  input  logic [vec_data_w_lp-1:0] core_r_data_i,
  output logic                     core_yumi_o
);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e   state, state_n;
  vec_cmd_s enq_cmd, head;
  logic     fifo_empty;
  logic     fifo_pop;
  logic     capture;
  logic     err_set;
  logic     resp_v;
  logic     resp_free;
  logic [vec_data_w_lp-1:0] resp_data;
  logic     err_q;

  assign enq_cmd = '{op: vec_op_e'(op_i), addr_a: addrA_i, addr_b: addrB_i,
                     addr_d: addrD_i, scalar: scalar_i, w_data: w_data_i};

  vec_cmd_fifo #(
    .width_p ($bits(vec_cmd_s)),
    .els_p   (cmd_els_p)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .data_i    (enq_cmd),
    .empty_o   (fifo_empty),
    .data_o    (head),
    .yumi_i    (fifo_pop)
  );

  assign core_op_o     = head.op;
  assign core_addrA_o  = head.addr_a;
  assign core_addrB_o  = head.addr_b;
  assign core_addrD_o  = head.addr_d;
  assign core_scalar_o = head.scalar;
  assign core_w_data_o = head.w_data;

  // A response slot is usable if empty now or drained by the host this same cycle.
  assign resp_free = !resp_v || yumi_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= S_IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n     = state;
    core_v_o    = 1'b0;
    core_yumi_o = 1'b0;
    fifo_pop    = 1'b0;
    capture     = 1'b0;
    err_set     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (!is_legal_op(head.op)) begin
            fifo_pop = 1'b1;
            err_set  = 1'b1;
          end else if (core_ready_i) begin
            core_v_o = 1'b1;
            state_n  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (core_done_i) begin
          if (head.op != OP_READ) begin
            fifo_pop = 1'b1;
            state_n  = S_IDLE;
          end else if (core_v_i && resp_free) begin
            capture     = 1'b1;
            core_yumi_o = 1'b1;
            fifo_pop    = 1'b1;
            state_n     = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // A capture in the same cycle as a host yumi keeps the slot occupied with new data.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_v    <= 1'b0;
      resp_data <= '0;
      err_q     <= 1'b0;
    end else begin
      if (capture) begin
        resp_v    <= 1'b1;
        resp_data <= core_r_data_i;
      end else if (yumi_i) begin
        resp_v <= 1'b0;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign v_o      = resp_v;
  assign r_data_o = resp_data;
  assign err_o    = err_q;
  assign busy_o   = !fifo_empty || (state != S_IDLE);

endmodule

// File: tb/tb_vec_cmd_dispatch.sv
// Scoreboard bench for vec_cmd_dispatch: expected issues and read responses are queued
// at stimulus time and popped by monitors when the DUT presents them.
module tb_vec_cmd_dispatch;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  d;
    logic [5:0]  s;
    logic [23:0] w;
  } exp_cmd_t;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        v_i = 1'b0;
  logic        ready_o;
  logic [3:0]  op_i = '0;
  logic [3:0]  addrA_i = '0;
  logic [3:0]  addrB_i = '0;
  logic [3:0]  addrD_i = '0;
  logic [5:0]  scalar_i = '0;
  logic [23:0] w_data_i = '0;
  logic        v_o;
  logic [23:0] r_data_o;
  logic        yumi_i = 1'b0;
  logic        err_o;
  logic        busy_o;
  logic        core_v_o;
  logic        core_ready_i = 1'b0;
  logic [3:0]  core_op_o;
  logic [3:0]  core_addrA_o;
  logic [3:0]  core_addrB_o;
  logic [3:0]  core_addrD_o;
  logic [5:0]  core_scalar_o;
  logic [23:0] core_w_data_o;
  logic        core_done_i = 1'b0;
  logic        core_v_i = 1'b0;
  logic [23:0] core_r_data_i = '0;
  logic        core_yumi_o;

  int          total_cnt = 0;
  int          bad_cnt = 0;
  int          core_lat = 2;
  int          reset_gen = 0;
  exp_cmd_t    issue_q[$];
  logic [23:0] rd_data_q[$];
  logic [23:0] resp_q[$];
  logic [45:0] active_cmd = '0;
  logic        acc;

  vec_cmd_dispatch #(.cmd_els_p(4)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
    .op_i(op_i), .addrA_i(addrA_i), .addrB_i(addrB_i), .addrD_i(addrD_i),
    .scalar_i(scalar_i), .w_data_i(w_data_i), .v_o(v_o), .r_data_o(r_data_o),
    .yumi_i(yumi_i), .err_o(err_o), .busy_o(busy_o), .core_v_o(core_v_o),
    .core_ready_i(core_ready_i), .core_op_o(core_op_o), .core_addrA_o(core_addrA_o),
    .core_addrB_o(core_addrB_o), .core_addrD_o(core_addrD_o),
    .core_scalar_o(core_scalar_o), .core_w_data_o(core_w_data_o),
    .core_done_i(core_done_i), .core_v_i(core_v_i), .core_r_data_i(core_r_data_i),
    .core_yumi_o(core_yumi_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic legal(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
                      4'b0110, 4'b1000, 4'b1001, 4'b1111};
  endfunction

  function automatic logic [45:0] pack_cmd(input exp_cmd_t c);
    return {c.op, c.a, c.b, c.d, c.s, c.w};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    total_cnt++;
    bad_cnt++;
    $display("[TB] FAIL %s: got timeout expected event", name);
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] d, input logic [5:0] s, input logic [23:0] w,
                               output logic accepted);
    exp_cmd_t c;
    v_i = 1'b1; op_i = op; addrA_i = a; addrB_i = b; addrD_i = d; scalar_i = s; w_data_i = w;
    accepted = ready_o;
    c = '{op: op, a: a, b: b, d: d, s: s, w: w};
    if (accepted && legal(op)) issue_q.push_back(c);
    @(posedge clk_i); #1;
    v_i = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy_o && n < 300) begin @(posedge clk_i); #1; n++; end
    if (n >= 300) timeoutFail(name);
  endtask

  task automatic pulseYumi();
    yumi_i = 1'b1;
    @(posedge clk_i); #1;
    yumi_i = 1'b0;
  endtask

  // Issue monitor: every core_v_o must match the oldest legal command still expected.
  initial begin
    exp_cmd_t e;
    forever begin
      @(negedge clk_i);
      if (reset_n_i && core_v_o) begin
        if (issue_q.size() == 0) begin
          checkOutput("unexpected_issue", {core_op_o, core_addrA_o}, 64'hdead);
        end else begin
          e = issue_q.pop_front();
          active_cmd = pack_cmd(e);
          checkOutput("issue_cmd", {core_op_o, core_addrA_o, core_addrB_o, core_addrD_o,
                                    core_scalar_o, core_w_data_o}, pack_cmd(e));
          checkOutput("issue_ready", core_ready_i, 1'b1);
        end
      end
    end
  end

  // Response monitor: each host consumption must present the next expected read data.
  initial begin
    forever begin
      @(negedge clk_i);
      if (reset_n_i && v_o && yumi_i) begin
        if (resp_q.size() == 0) checkOutput("unexpected_resp", r_data_o, 64'hdead);
        else checkOutput("resp_data", r_data_o, resp_q.pop_front());
      end
    end
  end

  // Core model: executes core_lat cycles, then holds done (and v for reads) until accepted.
  initial begin
    int  gen;
    int  n;
    logic done_ok;
    forever begin
      @(negedge clk_i);
      if (core_v_o && reset_n_i) begin
        gen = reset_gen;
        @(posedge clk_i); #1;
        for (int i = 0; i < core_lat && gen == reset_gen; i++) begin
          @(negedge clk_i);
          if (gen == reset_gen) begin
            checkOutput("hold_operands", {core_op_o, core_addrA_o, core_addrB_o, core_addrD_o,
                                          core_scalar_o, core_w_data_o}, active_cmd);
            checkOutput("no_reissue", core_v_o, 1'b0);
          end
          @(posedge clk_i); #1;
        end
        if (gen == reset_gen) begin
          core_done_i = 1'b1;
          core_v_i = (active_cmd[45:42] == 4'b1000);
          if (core_v_i) begin
            if (rd_data_q.size() == 0) begin
              timeoutFail("core_rd_data_missing");
              core_r_data_i = '0;
            end else begin
              core_r_data_i = rd_data_q.pop_front();
            end
          end
          done_ok = 1'b0;
          n = 0;
          while (!done_ok && gen == reset_gen && n < 200) begin
            @(negedge clk_i);
            if (gen == reset_gen)
              checkOutput("hold_at_done", {core_op_o, core_addrA_o}, active_cmd[45:38]);
            done_ok = !core_v_i || core_yumi_o;
            @(posedge clk_i); #1;
            n++;
          end
          if (n >= 200) timeoutFail("core_accept");
          core_done_i = 1'b0;
          core_v_i = 1'b0;
        end
      end
    end
  end

  initial begin
    int n;
    $display("[TB] starting");
    tick(2);
    checkOutput("rst_ready", ready_o, 1'b1);
    checkOutput("rst_v_o", v_o, 1'b0);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_err", err_o, 1'b0);
    checkOutput("rst_core_v", core_v_o, 1'b0);
    reset_n_i = 1'b1;
    core_ready_i = 1'b1;
    tick(1);

    // Test 1: add issues the cycle after enqueue, exactly once.
    applyStimulus(4'b0000, 4'd1, 4'd2, 4'd3, 6'h15, 24'hA5A5A5, acc);
    @(negedge clk_i);
    checkOutput("t1_issue_latency", core_v_o, 1'b1);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checkOutput("t1_issue_one_cycle", core_v_o, 1'b0);
    checkOutput("t1_busy_during", busy_o, 1'b1);
    waitIdle("t1_idle");
    tick(1);
    checkOutput("t1_busy_after", busy_o, 1'b0);

    // Test 2: read captured with core_yumi_o in the done cycle.
    rd_data_q.push_back(24'h123456);
    resp_q.push_back(24'h123456);
    applyStimulus(4'b1000, 4'd5, 4'd0, 4'd0, 6'h00, 24'h000000, acc);
    n = 0;
    while (!core_done_i && n < 50) begin @(negedge clk_i); n++; end
    if (n >= 50) timeoutFail("t2_done_wait");
    checkOutput("t2_yumi_with_done", core_yumi_o, 1'b1);
    @(posedge clk_i); #1;
    repeat (3) begin
      @(negedge clk_i);
      checkOutput("t2_v_hold", v_o, 1'b1);
      checkOutput("t2_data_hold", r_data_o, 24'h123456);
    end
    @(posedge clk_i); #1;
    pulseYumi();
    @(negedge clk_i);
    checkOutput("t2_v_cleared", v_o, 1'b0);
    @(posedge clk_i); #1;
    waitIdle("t2_idle");

    // Test 3: second read stalls on a full response buffer.
    rd_data_q.push_back(24'hABCDEF); resp_q.push_back(24'hABCDEF);
    rd_data_q.push_back(24'h0F0F0F); resp_q.push_back(24'h0F0F0F);
    applyStimulus(4'b1000, 4'd6, 4'd0, 4'd0, 6'h01, 24'h000000, acc);
    applyStimulus(4'b1000, 4'd7, 4'd0, 4'd0, 6'h02, 24'h000000, acc);
    n = 0;
    while (!(core_done_i && v_o) && n < 100) begin @(negedge clk_i); n++; end
    if (n >= 100) timeoutFail("t3_stall_wait");
    checkOutput("t3_stall_no_yumi", core_yumi_o, 1'b0);
    checkOutput("t3_stall_busy", busy_o, 1'b1);
    @(posedge clk_i); #1;
    tick(2);
    @(negedge clk_i);
    checkOutput("t3_still_stalled", core_yumi_o, 1'b0);
    checkOutput("t3_first_data_held", r_data_o, 24'hABCDEF);
    @(posedge clk_i); #1;
    yumi_i = 1'b1;
    @(negedge clk_i);
    checkOutput("t3_yumi_frees_slot", core_yumi_o, 1'b1);
    @(posedge clk_i); #1;
    yumi_i = 1'b0;
    @(negedge clk_i);
    checkOutput("t3_v_stays", v_o, 1'b1);
    checkOutput("t3_second_data", r_data_o, 24'h0F0F0F);
    @(posedge clk_i); #1;
    pulseYumi();
    waitIdle("t3_idle");
    checkOutput("t3_v_cleared", v_o, 1'b0);

    // Test 4: fill the FIFO while the core is not ready.
    core_ready_i = 1'b0;
    applyStimulus(4'b0001, 4'd1, 4'd1, 4'd1, 6'h11, 24'h111111, acc);
    checkOutput("t4_acc1", acc, 1'b1);
    applyStimulus(4'b0010, 4'd2, 4'd2, 4'd2, 6'h22, 24'h222222, acc);
    applyStimulus(4'b0100, 4'd3, 4'd3, 4'd3, 6'h33, 24'h333333, acc);
    checkOutput("t4_ready_before_full", ready_o, 1'b1);
    applyStimulus(4'b0101, 4'd4, 4'd4, 4'd4, 6'h04, 24'h444444, acc);
    checkOutput("t4_full_ready", ready_o, 1'b0);
    checkOutput("t4_no_issue_unready", core_v_o, 1'b0);
    applyStimulus(4'b0110, 4'd5, 4'd5, 4'd5, 6'h05, 24'h555555, acc);
    checkOutput("t4_fifth_refused", acc, 1'b0);
    core_ready_i = 1'b1;
    waitIdle("t4_idle");
    checkOutput("t4_all_issued", issue_q.size(), 0);
    checkOutput("t4_err_clear", err_o, 1'b0);

    // Test 5: illegal opcode dropped, sticky error, next command still issues.
    applyStimulus(4'b0011, 4'd8, 4'd8, 4'd8, 6'h08, 24'h888888, acc);
    applyStimulus(4'b0000, 4'd9, 4'd10, 4'd11, 6'h09, 24'h999999, acc);
    waitIdle("t5_idle");
    checkOutput("t5_err_set", err_o, 1'b1);
    checkOutput("t5_issued", issue_q.size(), 0);
    tick(3);
    checkOutput("t5_err_sticky", err_o, 1'b1);

    // Test 6: async reset while busy with three commands queued.
    core_lat = 6;
    core_ready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      applyStimulus(4'b1001, 4'(i), 4'(i + 1), 4'(i + 2), 6'(i), 24'h0C0C00 + 24'(i), acc);
    core_ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("t6_issue", core_v_o, 1'b1);
    @(posedge clk_i); #3;
    reset_n_i = 1'b0;
    reset_gen++;
    issue_q.delete();
    #1;
    checkOutput("t6_rst_ready", ready_o, 1'b1);
    checkOutput("t6_rst_v_o", v_o, 1'b0);
    checkOutput("t6_rst_r_data", r_data_o, 24'h000000);
    checkOutput("t6_rst_err", err_o, 1'b0);
    checkOutput("t6_rst_busy", busy_o, 1'b0);
    checkOutput("t6_rst_core_v", core_v_o, 1'b0);
    checkOutput("t6_rst_core_yumi", core_yumi_o, 1'b0);
    tick(2);
    reset_n_i = 1'b1;
    tick(10);
    checkOutput("t6_queue_discarded", busy_o, 1'b0);
    @(negedge clk_i);
    checkOutput("t6_no_issue_after", core_v_o, 1'b0);
    checkOutput("end_resp_q_empty", resp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
